// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 slave port among NUM_MASTERS masters.
// Ownership lasts a whole cyc tenure; a watchdog errors out transfers nobody answers.
module wb_rr_arbiter #(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   // requester side
   input  logic [NUM_MASTERS-1:0]                     m_cyc,
   input  logic [NUM_MASTERS-1:0]                     m_stb,
   input  logic [NUM_MASTERS-1:0]                     m_we,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]     m_adr,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     m_dat_w,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]   m_sel,
   input  logic [NUM_MASTERS-1:0][2:0]                m_cti,
   input  logic [NUM_MASTERS-1:0][1:0]                m_bte,
   output logic [NUM_MASTERS-1:0]                     m_ack,
   output logic [NUM_MASTERS-1:0]                     m_err,
   output logic [NUM_MASTERS-1:0]                     m_rty,
   output logic [DATA_WIDTH-1:0]                      m_dat_r,
   // shared downstream side
   output logic                                       s_cyc,
   output logic                                       s_stb,
   output logic                                       s_we,
   output logic [ADDR_WIDTH-1:0]                      s_adr,
   output logic [DATA_WIDTH-1:0]                      s_dat_w,
   output logic [DATA_WIDTH/8-1:0]                    s_sel,
   output logic [2:0]                                 s_cti,
   output logic [1:0]                                 s_bte,
   input  logic                                       s_ack,
   input  logic                                       s_err,
   input  logic                                       s_rty,
   input  logic [DATA_WIDTH-1:0]                      s_dat_r,
   // status
   output logic [NUM_MASTERS-1:0]                     grant,
   output logic                                       busy,
   output logic                                       timeout
);

   localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned WdW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WdW-1:0]  WdLast   = (TIMEOUT_CYCLES > 0) ? WdW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {StIdle, StOwned, StAbort} state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IdxW-1:0]        owner_q, owner_d;
   logic [WdW-1:0]         wd_cnt_q, wd_cnt_d;

   logic                   req_found;
   logic [IdxW-1:0]        pick;
   int unsigned            scan_idx;
   logic                   own_cyc;
   logic                   own_stb;
   logic                   slave_rsp;
   logic                   stalled;
   logic                   fire;

   // owner_q doubles as last_owner: it keeps the most recent winner after the tenure ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         owner_q  <= LastInit;
         wd_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         wd_cnt_q <= wd_cnt_d;
      end
   end

   always_comb begin
      req_found = 1'b0;
      pick      = owner_q;
      scan_idx  = 0;
      for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
         scan_idx = (int'(owner_q) + k) % NUM_MASTERS;
         if (!req_found && m_cyc[scan_idx[IdxW-1:0]]) begin
            req_found = 1'b1;
            pick      = scan_idx[IdxW-1:0];
         end
      end
   end

   assign own_cyc   = m_cyc[owner_q];
   assign own_stb   = m_stb[owner_q];
   assign slave_rsp = s_ack | s_err | s_rty;
   assign stalled   = (state_q == StOwned) && own_cyc && own_stb && !slave_rsp;
   // a response on the would-be fire cycle masks it through !slave_rsp in stalled
   assign fire      = (TIMEOUT_CYCLES != 0) && stalled && (wd_cnt_q == WdLast);

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      wd_cnt_d = '0;
      unique case (state_q)
         StIdle: begin
            if (req_found) begin
               state_d = StOwned;
               grant_d = NUM_MASTERS'(1) << pick;
               owner_d = pick;
            end
         end
         StOwned: begin
            if (!own_cyc) begin
               state_d = StIdle;
               grant_d = '0;
            end else if (fire) begin
               state_d = StAbort;
            end else if (stalled && (TIMEOUT_CYCLES != 0)) begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         StAbort: begin
            if (!own_cyc) begin
               state_d = StIdle;
               grant_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_w = '0;
      s_sel   = '0;
      s_cti   = '0;
      s_bte   = '0;
      m_ack   = '0;
      m_err   = '0;
      m_rty   = '0;
      timeout = 1'b0;
      m_dat_r = s_dat_r;
      if (state_q == StOwned) begin
         s_cyc          = own_cyc;
         s_stb          = own_stb;
         s_we           = m_we[owner_q];
         s_adr          = m_adr[owner_q];
         s_dat_w        = m_dat_w[owner_q];
         s_sel          = m_sel[owner_q];
         s_cti          = m_cti[owner_q];
         s_bte          = m_bte[owner_q];
         m_ack[owner_q] = s_ack;
         m_err[owner_q] = s_err | fire;
         m_rty[owner_q] = s_rty;
         timeout        = fire;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them whenever the DUT grants or responds.
module tb_wb_rr_arbiter;

   localparam int          N = 3;
   localparam logic [31:0] K = 32'h5A5A_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]        m_cyc, m_stb, m_we, m_ack, m_err, m_rty;
   logic [N-1:0][31:0]  m_adr, m_dat_w;
   logic [N-1:0][3:0]   m_sel;
   logic [N-1:0][2:0]   m_cti;
   logic [N-1:0][1:0]   m_bte;
   logic [31:0]         m_dat_r;
   logic                s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
   logic [31:0]         s_adr, s_dat_w, s_dat_r;
   logic [3:0]          s_sel;
   logic [2:0]          s_cti;
   logic [1:0]          s_bte;
   logic [N-1:0]        grant;
   logic                busy, timeout;

   wb_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
      .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
      .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_r(m_dat_r),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
      .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
      .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_r(s_dat_r),
      .grant(grant), .busy(busy), .timeout(timeout)
   );

   // slave model: acks after ack_delay wait states when enabled
   logic       ack_en = 1'b1;
   logic [3:0] ack_delay = 4'd0;
   logic [3:0] wcnt = 4'd0;
   assign s_ack   = s_cyc & s_stb & ack_en & (wcnt == ack_delay);
   assign s_err   = 1'b0;
   assign s_rty   = 1'b0;
   assign s_dat_r = s_adr ^ K;
   initial forever begin
      @(posedge clk);
      wcnt <= (s_cyc && s_stb && !s_ack) ? wcnt + 4'd1 : 4'd0;
   end

   typedef struct packed {logic [2:0] g; int gap;} gexp_t;
   typedef struct packed {
      logic [2:0] ack; logic [2:0] err; logic to; logic chk; logic [31:0] dat; logic [2:0] cti;
   } rexp_t;
   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t ge;
   rexp_t re;
   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // monitor
   logic [2:0] prev_g = '0;
   int         idle_run = 0;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_g   = '0;
         idle_run = 0;
      end else begin
         if (grant != '0 && prev_g == '0) begin
            if (gq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_grant: got %0h expected none", grant);
            end else begin
               ge = gq.pop_front();
               chk("grant", 64'(grant), 64'(ge.g));
               if (ge.gap >= 0) chk("idle_gap", 64'(idle_run), 64'(ge.gap));
            end
         end
         if (grant == '0) idle_run++;
         else idle_run = 0;
         if (|{m_ack, m_err, m_rty, timeout}) begin
            if (rq.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_rsp: got ack=%0h err=%0h to=%0b expected none",
                        m_ack, m_err, timeout);
            end else begin
               re = rq.pop_front();
               chk("ack", 64'(m_ack), 64'(re.ack));
               chk("err", 64'(m_err), 64'(re.err));
               chk("rty", 64'(m_rty), 64'(0));
               chk("timeout", 64'(timeout), 64'(re.to));
               if (re.chk) begin
                  chk("dat", 64'(m_dat_r), 64'(re.dat));
                  chk("cti", 64'(s_cti), 64'(re.cti));
               end
            end
         end
         prev_g = grant;
      end
   end

   // master driver
   int         beats_left[N];
   logic [2:0] smp_rsp, smp_err;
   logic       smp_stb;

   task automatic start(input int m, input int beats, input logic [31:0] adr, input int gap,
                        input int nacks, input bit to);
      rexp_t r;
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_adr[m] = adr;
      m_cti[m] = (beats > 1) ? 3'b010 : 3'b000;
      beats_left[m] = beats;
      gq.push_back('{g: 3'(1 << m), gap: gap});
      for (int b = 0; b < nacks; b++) begin
         r.ack = 3'(1 << m); r.err = '0; r.to = 1'b0; r.chk = 1'b1;
         r.dat = (adr + 32'(4 * b)) ^ K;
         r.cti = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
         rq.push_back(r);
      end
      if (to) begin
         r.ack = '0; r.err = 3'(1 << m); r.to = 1'b1; r.chk = 1'b0; r.dat = '0; r.cti = '0;
         rq.push_back(r);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      smp_rsp = m_ack | m_err | m_rty;
      smp_err = m_err;
      smp_stb = s_stb;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         if (beats_left[i] > 0 && smp_rsp[i]) begin
            beats_left[i]--;
            if (beats_left[i] == 0) begin
               m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_cti[i] = 3'b000;
            end else begin
               m_adr[i] = m_adr[i] + 32'd4;
               m_cti[i] = (beats_left[i] == 1) ? 3'b111 : 3'b010;
            end
         end
      end
   endtask

   task automatic run_until_done(input int limit);
      int n = 0;
      while ((beats_left[0] + beats_left[1] + beats_left[2]) > 0 && n < limit) begin
         tick();
         n++;
      end
      vectors++;
      if ((beats_left[0] + beats_left[1] + beats_left[2]) > 0) begin
         miscompares++;
         $display("FAIL wait_bound: got %0d pending beats expected 0",
                  beats_left[0] + beats_left[1] + beats_left[2]);
         for (int i = 0; i < N; i++) begin
            beats_left[i] = 0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
         end
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   int n, stb_cnt, acks;
   initial begin
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0;
      m_sel = {N{4'hF}}; m_cti = '0; m_bte = '0;
      for (int i = 0; i < N; i++) beats_left[i] = 0;
      #1 rst_n = 1'b0;
      // a requesting master must not leak through while in reset
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'hDEAD_BEEF;
      m_dat_w[1] = 32'h1234_5678; m_cti[1] = 3'b010; m_bte[1] = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy_to", 64'({busy, timeout}), 64'(0));
      chk("rst_s_ctl", 64'({s_cyc, s_stb, s_we, s_sel, s_cti, s_bte}), 64'(0));
      chk("rst_s_adr", 64'(s_adr), 64'(0));
      chk("rst_s_dat", 64'(s_dat_w), 64'(0));
      chk("rst_m_rsp", 64'({m_ack, m_err, m_rty}), 64'(0));
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_cti = '0; m_bte = '0;
      @(posedge clk); #1 rst_n = 1'b1;

      // 1: simultaneous requests rotate 0,1,2 then 0
      start(0, 1, 32'h100, -1, 1, 1'b0);
      start(1, 1, 32'h200, 1, 1, 1'b0);
      start(2, 1, 32'h300, 1, 1, 1'b0);
      run_until_done(40);
      start(0, 1, 32'h110, 1, 1, 1'b0);
      run_until_done(20);

      // 2: burst by master1 is not split by master0's request
      start(1, 4, 32'h1000, 1, 4, 1'b0);
      tick(); tick();
      start(0, 1, 32'h2000, 1, 1, 1'b0);
      run_until_done(40);

      // 3: watchdog fires on the 8th unanswered stb cycle
      ack_en = 1'b0;
      start(2, 1, 32'h3000, -1, 0, 1'b1);
      stb_cnt = 0; n = 0; smp_err = '0;
      while (!smp_err[2] && n < 30) begin
         tick();
         if (smp_stb) stb_cnt++;
         n++;
      end
      chk("wd_stb_cycles", 64'(stb_cnt), 64'(8));
      ack_en = 1'b1;
      @(negedge clk);
      chk("abort_s_cyc", 64'(s_cyc), 64'(0));
      chk("abort_busy", 64'(busy), 64'(1));
      run_until_done(5);
      start(0, 1, 32'h3100, -1, 1, 1'b0);
      run_until_done(20);

      // 4: ack on the would-be fire cycle wins
      ack_delay = 4'd7;
      start(1, 1, 32'h4000, -1, 1, 1'b0);
      stb_cnt = 0; n = 0; smp_rsp = '0;
      while (!smp_rsp[1] && n < 30) begin
         tick();
         if (smp_stb) stb_cnt++;
         n++;
      end
      chk("late_ack_stb_cycles", 64'(stb_cnt), 64'(8));
      run_until_done(5);
      ack_delay = 4'd0;

      // 5: async reset mid-burst, then master0 wins over master1
      start(0, 4, 32'h5000, -1, 2, 1'b0);
      acks = 0; n = 0;
      while (acks < 2 && n < 20) begin
         tick();
         if (smp_rsp[0]) acks++;
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_grant_busy", 64'({grant, busy, timeout}), 64'(0));
      chk("arst_s_ctl", 64'({s_cyc, s_stb, s_we, s_cti}), 64'(0));
      chk("arst_s_adr", 64'(s_adr), 64'(0));
      chk("arst_m_rsp", 64'({m_ack, m_err, m_rty}), 64'(0));
      for (int i = 0; i < N; i++) beats_left[i] = 0;
      m_cyc = '0; m_stb = '0; m_cti = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      start(0, 1, 32'h5100, -1, 1, 1'b0);
      start(1, 1, 32'h5200, 1, 1, 1'b0);
      run_until_done(30);

      // 6: a lone requester is re-granted every tenure
      for (int r = 0; r < 3; r++) begin
         start(2, 1, 32'h6000 + 32'(r * 16), (r == 0) ? -1 : 1, 1, 1'b0);
         run_until_done(20);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("grant_queue_drained", 64'(gq.size()), 64'(0));
      chk("rsp_queue_drained", 64'(rq.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
